evm_vote_ctrl: RTL

Vote-capture controller directly upstream of the 16-entry x 10-bit vote-count RAM. Accepts one candidate selection per ballot press and performs a read-increment-write of that candidate's count in the RAM. Also drives the RAM's clear and read-out path for the result-display phase. The RAM read port is combinational whenever its write enable is low; its write and clear are synchronous.

---
 rtl/evm_pkg.sv | 18 +
 rtl/evm_sat_inc.sv | 21 ++
 rtl/evm_vote_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared constants and FSM state type for the EVM vote-capture controller.
package evm_pkg;

    localparam int CNT_W        = 10;
    localparam int ADDR_W       = 5;
    localparam int NUM_CAND_MAX = 16;
    localparam int TOT_W        = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        LOCK  = 3'd3,
        CLEAR = 3'd4
    } evm_ctrl_state_t;

endpackage

// File: rtl/evm_sat_inc.sv
// Combinational W-bit incrementer that holds at the all-ones maximum.
module evm_sat_inc
    import evm_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic [W-1:0] in_val,
    output logic [W-1:0] out_val
);

    // Saturating add-one.
    always_comb begin
        out_val = in_val;
        if (&in_val) begin
            out_val = in_val;
        end else begin
            out_val = in_val + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/evm_vote_ctrl.sv
// Vote-capture controller: read-increment-write of per-candidate counts, RAM clear
// and result read-out. Define EVM_TOTAL_EN to add the saturating total_votes output.
module evm_vote_ctrl
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vote_valid,
    input  logic [3:0]        cand_id,
    output logic              vote_ready,
    output logic              vote_done,
    output logic              vote_err,
    input  logic              result_en,
    input  logic [3:0]        result_addr,
    output logic [CNT_W-1:0]  result_data,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              ram_wr_en,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [CNT_W-1:0]  ram_wdata,
    input  logic [CNT_W-1:0]  ram_rdata
`ifdef EVM_TOTAL_EN
    ,
    output logic [TOT_W-1:0]  total_votes
`endif
);

    localparam logic [4:0] NUM_CAND_L = 5'(NUM_CAND);

    evm_ctrl_state_t   state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic              ram_reset_q, ram_reset_d;
    logic              vote_done_q, vote_done_d;
    logic              vote_err_q, vote_err_d;
    logic              clear_done_q, clear_done_d;
    logic [CNT_W-1:0]  count_inc_s;
    logic              result_mode_s;
    logic              cand_ok_s;

    evm_sat_inc #(.W(CNT_W)) u_cnt_inc (
        .in_val  (ram_rdata),
        .out_val (count_inc_s)
    );

    assign cand_ok_s     = ({1'b0, cand_id} < NUM_CAND_L);
    assign result_mode_s = (state_q == IDLE) && !clear_req && result_en;

    // Read-out path is combinational so the display tracks result_addr directly.
    assign ram_addr    = result_mode_s ? {1'b0, result_addr} : ram_addr_q;
    assign result_data = result_mode_s ? ram_rdata : {CNT_W{1'b0}};
    assign vote_ready  = (state_q == IDLE) && !result_en && !clear_req;
    assign ram_wdata   = count_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_reset   = ram_reset_q;
    assign vote_done   = vote_done_q;
    assign vote_err    = vote_err_q;
    assign clear_done  = clear_done_q;

    // Next-state and next-output logic; pulse outputs default low every cycle.
    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        count_d      = count_q;
        ram_wr_en_d  = 1'b0;
        ram_reset_d  = 1'b0;
        vote_done_d  = 1'b0;
        vote_err_d   = 1'b0;
        clear_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d      = CLEAR;
                    ram_reset_d  = 1'b1;
                    clear_done_d = 1'b1;
                end else if (result_en) begin
                    state_d = IDLE;
                end else if (vote_valid) begin
                    if (cand_ok_s) begin
                        ram_addr_d = {1'b0, cand_id};
                        state_d    = READ;
                    end else begin
                        vote_err_d = 1'b1;
                        state_d    = LOCK;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                count_d     = count_inc_s;
                ram_wr_en_d = 1'b1;
                vote_done_d = 1'b1;
                state_d     = WRITE;
            end
            WRITE: begin
                state_d = LOCK;
            end
            // Holding the button never re-arms; the press must be released first.
            LOCK: begin
                if (!vote_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ram_addr_q   <= {ADDR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            ram_wr_en_q  <= 1'b0;
            ram_reset_q  <= 1'b0;
            vote_done_q  <= 1'b0;
            vote_err_q   <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            count_q      <= count_d;
            ram_wr_en_q  <= ram_wr_en_d;
            ram_reset_q  <= ram_reset_d;
            vote_done_q  <= vote_done_d;
            vote_err_q   <= vote_err_d;
            clear_done_q <= clear_done_d;
        end
    end

`ifdef EVM_TOTAL_EN
    logic [TOT_W-1:0] total_q, total_d;
    logic [TOT_W-1:0] total_inc_s;

    evm_sat_inc #(.W(TOT_W)) u_tot_inc (
        .in_val  (total_q),
        .out_val (total_inc_s)
    );

    // Running total follows the issued writes and is wiped with the RAM.
    always_comb begin
        total_d = total_q;
        if (state_q == CLEAR) begin
            total_d = {TOT_W{1'b0}};
        end else if (vote_done_q) begin
            total_d = total_inc_s;
        end else begin
            total_d = total_q;
        end
    end

    // Total counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= {TOT_W{1'b0}};
        end else begin
            total_q <= total_d;
        end
    end

    assign total_votes = total_q;
`endif

endmodule
